fifo_rf: RTL and testbench

//   Parametrised synchronous FIFO. Storage is an internal 2^AW x DW register file

---
 rtl/fifo_rf.sv | 146 ++++++++++++++
 tb/tb_fifo_rf.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rf.sv
// fifo_rf: parametrised synchronous FIFO built on a 2^AW x DW register file.
// One write port, one FIFO read port, one combinational debug read port.
// Occupancy count is the single source of the full/empty flags; rejected
// pushes/pops raise one-cycle ovf/udf pulses and change nothing else.
// Build option: define FIFO_RF_FWFT_EN for first-word fall-through reads
// (dout shows the head word combinationally). When it is undefined, reads are
// registered with one cycle of latency.
module fifo_rf #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf,
    input  logic [AW-1:0] dbg_ra,
    output logic [DW-1:0] dbg_rd
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Storage is deliberately left out of reset: only pointers and count are
    // cleared, so stale words may remain visible on the debug port.
    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;

    logic          push_ok;
    logic          pop_ok;

    // Accept/reject decisions; a pop frees a slot, so push into a full FIFO
    // is accepted when a pop is accepted on the same edge.
    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
    end

    // Next-state for pointers, occupancy and error pulses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push & ~push_ok;
        udf_d    = pop & ~pop_ok;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Register file write port; no reset on the data array.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Debug port reads the array directly, so a write shows up after its edge.
    always_comb begin
        dbg_rd = mem_q[dbg_ra];
    end

    // Status outputs.
    always_comb begin
        count = count_q;
        ovf   = ovf_q;
        udf   = udf_q;
    end

`ifdef FIFO_RF_FWFT_EN
    // Head word falls through; a pop consumes what is already on dout.
    always_comb begin
        dout       = empty ? '0 : mem_q[rd_ptr_q];
        dout_valid = ~empty;
    end
`else
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;

    // Registered read: capture the head word on an accepted pop, else hold.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = pop_ok;
        if (pop_ok) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    // Read data register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Drive read outputs from the read register.
    always_comb begin
        dout       = dout_q;
        dout_valid = dout_valid_q;
    end
`endif

endmodule

// File: tb/tb_fifo_rf.sv
// tb_fifo_rf: directed plus randomised checks of fifo_rf (DW=4, AW=3)
// against a queue-based reference model.
module tb_fifo_rf;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] din = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic [AW-1:0] dbg_ra = '0;
    logic [DW-1:0] dbg_rd;

    fifo_rf #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .din        (din),
        .pop        (pop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ovf        (ovf),
        .udf        (udf),
        .dbg_ra     (dbg_ra),
        .dbg_rd     (dbg_rd)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, storage as a plain array.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] mmem [DEPTH];
    bit            mvld [DEPTH];
    int            wr_n;
    logic [DW-1:0] reg_dout;
    logic          reg_dv;
    logic          exp_ovf;
    logic          exp_udf;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] e_dout;
        logic          e_dv;
`ifdef FIFO_RF_FWFT_EN
        e_dout = (mq.size() != 0) ? mq[0] : '0;
        e_dv   = (mq.size() != 0);
`else
        e_dout = reg_dout;
        e_dv   = reg_dv;
`endif
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full",  32'(full),  32'(mq.size() == DEPTH));
        chk("ovf",   32'(ovf),   32'(exp_ovf));
        chk("udf",   32'(udf),   32'(exp_udf));
        chk("dout",  32'(dout),  32'(e_dout));
        chk("dout_valid", 32'(dout_valid), 32'(e_dv));
        if (mvld[dbg_ra]) chk("dbg_rd", 32'(dbg_rd), 32'(mmem[dbg_ra]));
    endtask

    // One clock: drive at negedge, apply the rules to the model, check after the edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit o);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        push   = p;
        din    = d;
        pop    = o;
        dbg_ra = AW'($urandom_range(0, DEPTH - 1));
        pop_ok  = o && (mq.size() != 0);
        push_ok = p && ((mq.size() < DEPTH) || pop_ok);
        @(posedge clk);
        #1;
        exp_ovf = p && !push_ok;
        exp_udf = o && !pop_ok;
        reg_dv  = pop_ok;
        if (pop_ok) reg_dout = mq.pop_front();
        if (push_ok) begin
            mq.push_back(d);
            mmem[wr_n] = d;
            mvld[wr_n] = 1'b1;
            wr_n = (wr_n + 1) % DEPTH;
        end
        check_all();
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        mq.delete();
        wr_n     = 0;
        reg_dout = '0;
        reg_dv   = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic dbg_chk(input int a);
        dbg_ra = AW'(a);
        #1;
        chk("dbg_dir", 32'(dbg_rd), 32'(mmem[a]));
    endtask

    initial begin
        logic [DW-1:0] v;
        wr_n = 0; reg_dout = '0; reg_dv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        for (int i = 0; i < DEPTH; i++) mvld[i] = 1'b0;

        // Power-on reset state.
        #12;
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // Reset mid-operation discards contents.
        for (int i = 1; i <= 3; i++) step(1, DW'(i + 4), 0);
        step(0, 0, 1);
        do_reset();
        step(0, 0, 0);

        // Fill, then overflow.
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0);
        step(1, 4'h9, 0);
        step(0, 0, 0);
        for (int i = 0; i < DEPTH; i++) dbg_chk(i);

        // Drain, then underflow.
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Wrap the pointers.
        for (int i = 0; i < 5; i++) step(1, DW'($urandom_range(0, 15)), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, DW'(4'hA + i), 0);
        dbg_chk(5);
        dbg_chk(2);
        dbg_chk(0);
        for (int i = 0; i < 6; i++) step(0, 0, 1);

        // Simultaneous push/pop at full and at empty.
        for (int i = 0; i < 8; i++) step(1, DW'($urandom_range(0, 15)), 0);
        step(1, 4'h5, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        step(1, 4'h3, 1);
        step(0, 0, 1);

        // Single word through an empty FIFO (fall-through visible in FWFT build).
        step(1, 4'h6, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Randomised traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            v = DW'($urandom_range(0, 15));
            step(bit'($urandom_range(0, 1)), v, bit'($urandom_range(0, 1)));
            if (i == 200) do_reset();
        end
        for (int i = 0; i < 100; i++) begin
            v = DW'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
